// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a two-entry skid buffer; 1-cycle latency, full throughput.
// in_ready is registered-state only (drops in TWO); flush turns held entries into bubbles.
module pipe_stage_elastic #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 137,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              load_main_in, load_main_skid, load_skid;
  logic              accept, take;

  assign in_ready  = (state != TWO) && !rst;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Flush overrides everything: a same-cycle accept is dropped, a take is simply consumed.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && take) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (take) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (take) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in)        main_ctrl <= in_ctrl;
      else if (load_main_skid) main_ctrl <= skid_ctrl;
      if (load_skid)           skid_ctrl <= in_ctrl;
    end
  end

  // Data bundle is never scrubbed by flush, only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in)        main_data <= in_data;
      else if (load_main_skid) main_data <= skid_data;
      if (load_skid)           skid_data <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed test-plan steps followed by random traffic, checked against a queue model.
module tb_pipe_stage_elastic;
  localparam int CW = 12;
  localparam int DW = 137;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, flush, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt;
  logic          s_in_ready, s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [DW-1:0] s_out_data;
  logic [2:0]    s_stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_elastic dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_elastic #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl),
    .out_data(s_out_data), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] last_head;
  int            m_cnt, m_cnt_sat;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    last_head = '0;
    m_cnt     = 0;
    m_cnt_sat = 0;
  endtask

  // Applies the inputs present just before a rising edge to the reference queue.
  task automatic model_edge();
    bit   acc, tk;
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    acc = in_valid && (q.size() < 2);
    tk  = (q.size() > 0) && out_ready;
    if ((q.size() > 0) && !out_ready) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_sat < 7) m_cnt_sat++;
    end
    if (flush) begin
      q.delete();
    end else begin
      if (tk) void'(q.pop_front());
      if (acc) begin
        e.ctrl = in_ctrl;
        e.data = in_data;
        q.push_back(e);
      end
    end
    if (q.size() > 0) last_head = q[0].data;
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, (q.size() < 2) && !rst);
    chk("out_ctrl", out_ctrl, (q.size() != 0) ? q[0].ctrl : '0);
    chk("out_data", out_data, (q.size() != 0) ? q[0].data : last_head);
    chk("stall_cnt", stall_cnt, m_cnt);
    chk("sat_stall_cnt", s_stall_cnt, m_cnt_sat);
    chk("sat_out_data", s_out_data, (q.size() != 0) ? q[0].data : last_head);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    logic [159:0] rnd;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    model_reset();
    #3;
    check_all();
    tick();
    rst = 1'b0;
    tick();

    // streaming: 8 back-to-back entries
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, CW'(k), DW'(k));
      tick();
    end
    drive(1'b0, '0, '0);
    tick();

    // stall fill: A then B under back-pressure
    out_ready = 1'b0;
    drive(1'b1, 12'h0A, DW'(8'h11));
    tick();
    drive(1'b1, 12'h0B, DW'(8'h22));
    tick();
    drive(1'b0, '0, '0);
    chk("fill_in_ready_low", in_ready, 1'b0);
    chk("fill_head_held", out_data, DW'(8'h11));
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b1;
    tick();
    chk("drain_second", out_data, DW'(8'h22));
    chk("drain_in_ready", in_ready, 1'b1);
    tick();

    // flush in TWO with a colliding input C
    out_ready = 1'b0;
    drive(1'b1, 12'h0D, DW'(8'h44));
    tick();
    drive(1'b1, 12'h0E, DW'(8'h55));
    tick();
    drive(1'b1, 12'hFFF, DW'(8'h33));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_out_ctrl", out_ctrl, '0);
    chk("flush_data_kept", out_data, DW'(8'h44));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // reset mid-stall at stall_cnt=5
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 12'h111, DW'(8'h66));
    tick();
    drive(1'b1, 12'h222, DW'(8'h77));
    tick();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 20 && m_cnt < 5; i++) tick();
    chk("pre_rst_cnt", stall_cnt, 16'd5);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl", out_ctrl, '0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    check_all();
    tick();
    rst = 1'b0;
    tick();

    // saturation of the 3-bit counter
    out_ready = 1'b0;
    drive(1'b1, 12'h5A5, DW'(8'h99));
    tick();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_stops_at_7", s_stall_cnt, 3'd7);
    chk("wide_cnt_10", stall_cnt, 16'd10);
    out_ready = 1'b1;
    tick();

    // bubble gating in EMPTY
    drive(1'b0, '1, '0);
    tick();
    chk("bubble_out_ctrl", out_ctrl, '0);
    chk("bubble_out_valid", out_valid, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      drive(($urandom % 4) != 0, CW'($urandom), rnd[DW-1:0]);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 16) == 0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised, elastic successor to the fixed ID/EX pipeline register. It carries a control bundle and a data bundle between two pipeline stages under a valid/ready handshake. A two-entry skid buffer keeps full throughput with registered back-pressure, and a flush input kills in-flight instructions by converting them to bubbles. It is instantiated between decode and execute first, with later reuse at EX/MEM and MEM/WB.

## Interface
Parameters:
- CTRL_W, 12, width of the control bundle (Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Jal, Jalr, AuipcLui[1:0], ALUOp[2:0]); these bits are zeroed on flush/bubble.
- DATA_W, 137, width of the data bundle (pc, read_data_1, read_data_2, imm, instr_3014, instr_117); these bits are never zeroed except at reset.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  stage presents a valid instruction.
- out_ready  in  1  downstream accepts this cycle; low means stall.
- out_ctrl  out  CTRL_W  control of the head entry; forced to 0 whenever out_valid=0.
- out_data  out  DATA_W  data of the head entry.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage:
  - main entry {ctrl, data}, which is the head and drives the outputs.
  - skid entry {ctrl, data}.
  - 2-bit state: EMPTY, ONE, TWO.
- Outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO) and not rst. It is a function of registered state only and has no combinational path from out_ready.
- Events:
  - accept = in_valid & in_ready.
  - take = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY: accept → ONE, main←in; otherwise stay EMPTY.
  - ONE, accept & take → ONE, main←in.
  - ONE, accept & !take → TWO, skid←in.
  - ONE, !accept & take → EMPTY.
  - ONE, neither → ONE, hold.
  - TWO, take → ONE, main←skid; no accept is possible because in_ready=0.
  - TWO, !take → TWO, hold.
- Flush, which has highest priority:
  - Next state is EMPTY.
  - main.ctrl and skid.ctrl are cleared to 0; data fields hold their values.
  - A same-cycle accept is dropped; the input is not stored.
  - A same-cycle take still counts as consumed by downstream.
- Bubble gating: out_ctrl = main.ctrl when out_valid, else 0. Downstream therefore never sees a write-enable from a bubble.
- stall_cnt:
  - Increments by 1 each cycle in which out_valid & !out_ready.
  - Saturates at 2^CNT_W−1.
  - Cleared only by rst; flush does not clear it.
- Ordering is strict FIFO: skid contents never bypass main.

## Timing
- Reset (asynchronous, immediate):
  - state=EMPTY, all ctrl and data storage = 0, stall_cnt = 0.
  - Outputs during and after reset: out_valid=0, out_ctrl=0, out_data=0, in_ready=0 while rst=1, in_ready=1 on the first cycle after rst deasserts.
- Latency: an entry accepted at edge N is visible on the out_* ports from edge N+1.
- Throughput: 1 entry/cycle while out_ready=1; the skid is never used in that case.
- Back-pressure: in_ready falls one cycle after the first unmatched accept under stall (state TWO). At most 2 entries are held.
- rst asserted mid-transfer discards both entries. A transfer in the same cycle as rst is not completed on either side.
- flush takes effect at the next edge. out_valid=0 from edge N+1 when flush is high in cycle N.

## Test plan
- Streaming: reset, then out_ready=1 and in_valid=1 for 8 cycles with in_ctrl=k, in_data=k for k=1..8. Required: outputs 1..8 on consecutive cycles, 1-cycle latency, stall_cnt=0, in_ready stays 1.
- Stall fill: hold out_ready=0, send A=0x11 and B=0x22. Required: in_ready=0 after B is accepted, out_data=0x11 held, stall_cnt increments each cycle. Then raise out_ready: required out 0x11 then 0x22, and in_ready=1 one cycle after the first take.
- Flush in TWO with in_valid=1 (C=0x33): required out_valid=0 and out_ctrl=0 next cycle, C never appears at the output, and the data bundle retains its old bits.
- Reset mid-stall: state TWO, stall_cnt=5, assert rst between edges. Required: out_valid, out_ctrl and stall_cnt are 0 immediately, without waiting for clk; in_ready=0 during reset.
- Counter saturation with CNT_W=3: stall for 10 cycles. Required: stall_cnt stops at 7.
- Bubble gating: with state EMPTY, drive in_ctrl to all ones and in_valid=0. Required: out_ctrl=0 and out_valid=0.
